accumulator_core_param: RTL and testbench
=========================================

// Module: accumulator_core_param
// PURPOSE
//  Parametrised multicycle accumulator processor core; next generation of the tt03p5 accumulator microcontroller.
//  Generalises data/address width and moves memory off-core behind a req/ack handshake, so wait-state memories are supported.
//  Sits between the top-level wrapper and a memory/CSR fabric; internal PC, ACC, IR, SEG, IO_OUT registers and FSM.
// PARAMETERS
//  DATA_W  8  datapath/ACC/memory data width (>=8; instructions use mem_rdata[7:0])
//  ADDR_W  8  memory address width (>=5); SEG width is ADDR_W-4
// PORTS
//  clk          in   1       clock, rising edge
//  rst_n        in   1       synchronous active-low reset
//  proc_en      in   1       1 = run; 0 = pause at next instruction boundary
//  halt         out  1       1 after HLT executed
//  mem_req      out  1       memory transaction request
//  mem_we       out  1       1 = write, 0 = read (valid with mem_req)
//  mem_addr     out  ADDR_W  transaction address
//  mem_wdata    out  DATA_W  write data (= ACC)
//  mem_rdata    in   DATA_W  read data, sampled on the edge where mem_ack=1
//  mem_ack      in   1       transaction complete; only meaningful while mem_req=1
//  io_in        in   DATA_W  input port
//  io_out       out  DATA_W  registered output port
//  scan_enable  in   1       scan shift enable (SCAN_CHAIN_EN only)
//  scan_in      in   1       scan serial in
//  scan_out     out  1       scan serial out
// BEHAVIOUR
//  Reset (rst_n=0 at an edge): PC, ACC, IR, SEG, io_out = 0; state FETCH; halt=0; mem_req=0, mem_we=0; overrides everything incl. an open transaction.
//  FSM: FETCH -> EXEC -> FETCH; HLT -> HALT (absorbing until reset).
//   FETCH: if proc_en=0 then mem_req=0 and stay. Otherwise mem_req=1, mem_we=0, mem_addr=PC; on ack: IR<=rdata[7:0], PC<=PC+1 (mod 2^ADDR_W), go EXEC.
//   EXEC: memory ops hold mem_req=1 until ack, then go FETCH. Other ops complete in one EXEC cycle.
//  Handshake: once mem_req=1, mem_addr/mem_we/mem_wdata are stable until the ack edge. Ack in the first req cycle is legal (zero-wait).
//   proc_en falling mid-transaction does not abort it; the pause takes effect at the next FETCH.
//  Zero-wait latency: 2 cycles per instruction. Each wait cycle adds 1.
//  ISA: op=IR[7:4], k=IR[3:0], direct address D={SEG,k}. Arithmetic is mod 2^DATA_W; k is zero-extended. ZF = (ACC==0).
//   0 LDA D: ACC<=M[D]   1 STA D: M[D]<=ACC   2 ADD D   3 SUB D (ACC-M)   4 AND D   5 OR D   6 XOR D
//   7 ADDI k: ACC<=ACC+k   8 SETSEG k: SEG<=k[SEG_W-1:0], zero-extended if SEG_W>4
//   9 BEQ / A BNE: if (ZF / !ZF) PC<=PC +/- k[2:0]; k[3]=1 means minus. PC is already incremented; wraps mod 2^ADDR_W.
//   B JMP: PC<=ACC[ADDR_W-1:0]   C LDAR: ACC<=M[ACC[ADDR_W-1:0]]
//   D SHIFT: k[3]=0 shift left, 1 shift right; logical, amount k[2:0]; amount>=DATA_W gives 0
//   E k[3]=0 IN: ACC<=io_in; k[3]=1 OUT: io_out<=ACC   F k=F HLT; other F = NOP
//  HALT: halt=1, mem_req=0, no state changes except via reset/scan.
// CONFIGURATION
//  SCAN_CHAIN_EN defined: when scan_enable=1, FSM/registers freeze and shift 1 bit/cycle.
//   Chain order: scan_in -> state(2) -> SEG -> PC -> IR -> ACC -> io_out -> scan_out (MSB first per register).
//   mem_req=0 during scan; reset has priority over scan.
//  SCAN_CHAIN_EN undefined: scan_enable and scan_in ignored; scan_out tied 0. Ports remain present.
// TESTING
//  Reset: rst_n=0 for 2 cycles mid-fetch with ack low -> next cycle all outputs 0, mem_req=0, halt=0.
//  Zero-wait (ack tied 1): mem[0]=0x05 (LDA 5), mem[1]=0x71, mem[5]=0x7F -> ACC=0x80 after 4 cycles; fetch addrs 0,5,1.
//  Wait states (ack delayed 3 cycles each): same program -> mem_addr/mem_req stable while waiting; ACC=0x80 after 16 cycles.
//  Wrap: ACC=0, mem[0]=0x9A (BEQ -2) -> PC=0xFF. ACC=0xFF, ADD M=0x02 -> ACC=0x01.
//  HLT=0xFF -> halt=1, mem_req stays 0. proc_en=0 during a waited STA -> write completes, then no further req.
//  SCAN_CHAIN_EN: shift in known pattern over 2+ADDR_W-4+ADDR_W+8+2*DATA_W cycles -> registers match; shift out returns the pattern.

Source files
------------

// File: rtl/accumulator_core_param.sv
`timescale 1ns/1ps
// accumulator_core_param
//   Parametrised multicycle accumulator core. Memory lives off-core behind a
//   req/ack handshake, so any number of wait states is tolerated.
//   Optional feature macro: SCAN_CHAIN_EN (serial scan of state/SEG/PC/IR/ACC/io_out).
// Ports
//   clk, rst_n          : clock (rising edge), synchronous active-low reset
//   proc_en             : run enable, pause takes effect at an instruction boundary
//   halt                : set once HLT has executed
//   mem_req/mem_we      : transaction request / write strobe
//   mem_addr/mem_wdata  : transaction address / write data (always ACC)
//   mem_rdata/mem_ack   : read data / completion, sampled on the ack edge
//   io_in/io_out        : input port / registered output port
//   scan_enable/scan_in/scan_out : scan shift controls (inert without SCAN_CHAIN_EN)
module accumulator_core_param #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              proc_en,
  output logic              halt,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] io_in,
  output logic [DATA_W-1:0] io_out,
  input  logic              scan_enable,
  input  logic              scan_in,
  output logic              scan_out
);
  localparam int SEG_W = ADDR_W - 4;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t            state_r;
  logic [ADDR_W-1:0] pc_r;
  logic [DATA_W-1:0] acc_r;
  logic [DATA_W-1:0] io_out_r;
  logic [7:0]        ir_r;
  logic [SEG_W-1:0]  seg_r;
  // Remembers an issued fetch so a proc_en drop cannot withdraw it mid-wait.
  logic              fetch_busy_r;

  logic [3:0]        op_s;
  logic [3:0]        k_s;
  logic [ADDR_W-1:0] dir_addr_s;
  logic [ADDR_W-1:0] acc_addr_s;
  logic [ADDR_W-1:0] br_target_s;
  logic [DATA_W-1:0] mem_result_s;
  logic              zf_s;
  logic              mem_op_s;
  logic              scan_shift_s;
  logic              mem_req_s;
  logic              mem_we_s;
  logic [ADDR_W-1:0] mem_addr_s;

  assign op_s        = ir_r[7:4];
  assign k_s         = ir_r[3:0];
  assign dir_addr_s  = {seg_r, k_s};
  assign acc_addr_s  = ADDR_W'(acc_r);
  assign zf_s        = (acc_r == {DATA_W{1'b0}});
  assign mem_op_s    = (op_s <= 4'h6) || (op_s == 4'hC);
  // Branch offset is sign-magnitude: k[3] selects direction, k[2:0] is the distance.
  assign br_target_s = k_s[3] ? (pc_r - ADDR_W'(k_s[2:0])) : (pc_r + ADDR_W'(k_s[2:0]));

`ifdef SCAN_CHAIN_EN
  localparam int CHAIN_W = 2 + SEG_W + ADDR_W + 8 + 2 * DATA_W;
  logic [CHAIN_W-1:0] chain_s;
  logic [CHAIN_W-1:0] chain_nxt_s;
  // io_out sits at the output end so each register leaves the chain MSB first.
  assign chain_s      = {io_out_r, acc_r, ir_r, pc_r, seg_r, state_r};
  assign chain_nxt_s  = {chain_s[CHAIN_W-2:0], scan_in};
  assign scan_shift_s = scan_enable;
  assign scan_out     = io_out_r[DATA_W-1];
`else
  logic unused_scan_s;
  assign unused_scan_s = scan_enable ^ scan_in;
  assign scan_shift_s  = 1'b0;
  assign scan_out      = 1'b0;
`endif

  // Bus request decode; reset and scan force the bus idle.
  always_comb begin
    mem_req_s  = 1'b0;
    mem_we_s   = 1'b0;
    mem_addr_s = pc_r;
    if (!rst_n || scan_shift_s) begin
      mem_req_s = 1'b0;
    end else begin
      case (state_r)
        ST_FETCH: begin
          mem_req_s  = proc_en | fetch_busy_r;
          mem_addr_s = pc_r;
        end
        ST_EXEC: begin
          mem_req_s  = mem_op_s;
          mem_we_s   = mem_op_s && (op_s == 4'h1);
          mem_addr_s = (op_s == 4'hC) ? acc_addr_s : dir_addr_s;
        end
        default: begin
          mem_req_s = 1'b0;
        end
      endcase
    end
  end

  // ALU result for the memory-operand instructions.
  always_comb begin
    mem_result_s = acc_r;
    case (op_s)
      4'h0:    mem_result_s = mem_rdata;
      4'h2:    mem_result_s = acc_r + mem_rdata;
      4'h3:    mem_result_s = acc_r - mem_rdata;
      4'h4:    mem_result_s = acc_r & mem_rdata;
      4'h5:    mem_result_s = acc_r | mem_rdata;
      4'h6:    mem_result_s = acc_r ^ mem_rdata;
      4'hC:    mem_result_s = mem_rdata;
      default: mem_result_s = acc_r;
    endcase
  end

  // Architectural state, FSM and scan shifting.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= ST_FETCH;
      pc_r         <= {ADDR_W{1'b0}};
      acc_r        <= {DATA_W{1'b0}};
      io_out_r     <= {DATA_W{1'b0}};
      ir_r         <= 8'h00;
      seg_r        <= {SEG_W{1'b0}};
      fetch_busy_r <= 1'b0;
    end else if (scan_shift_s) begin
`ifdef SCAN_CHAIN_EN
      {io_out_r, acc_r, ir_r, pc_r, seg_r} <= chain_nxt_s[CHAIN_W-1:2];
      state_r <= state_t'(chain_nxt_s[1:0]);
`endif
    end else begin
      case (state_r)
        ST_FETCH: begin
          if (mem_req_s && mem_ack) begin
            ir_r         <= mem_rdata[7:0];
            pc_r         <= pc_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            state_r      <= ST_EXEC;
            fetch_busy_r <= 1'b0;
          end else if (mem_req_s) begin
            fetch_busy_r <= 1'b1;
          end
        end
        ST_EXEC: begin
          if (mem_op_s) begin
            if (mem_ack) begin
              acc_r   <= mem_result_s;
              state_r <= ST_FETCH;
            end
          end else begin
            state_r <= ST_FETCH;
            case (op_s)
              4'h7: acc_r <= acc_r + DATA_W'(k_s);
              4'h8: seg_r <= SEG_W'(k_s);
              4'h9: if (zf_s)  pc_r <= br_target_s;
              4'hA: if (!zf_s) pc_r <= br_target_s;
              4'hB: pc_r <= acc_addr_s;
              4'hD: acc_r <= k_s[3] ? (acc_r >> k_s[2:0]) : (acc_r << k_s[2:0]);
              4'hE: begin
                if (k_s[3]) io_out_r <= acc_r;
                else        acc_r    <= io_in;
              end
              4'hF: if (k_s == 4'hF) state_r <= ST_HALT;
              default: ;
            endcase
          end
        end
        ST_HALT: state_r <= ST_HALT;
        default: state_r <= ST_FETCH;
      endcase
    end
  end

  assign halt      = (state_r == ST_HALT);
  assign mem_req   = mem_req_s;
  assign mem_we    = mem_we_s;
  assign mem_addr  = mem_addr_s;
  assign mem_wdata = acc_r;
  assign io_out    = io_out_r;

endmodule

// File: tb/tb_accumulator_core_param.sv
`timescale 1ns/1ps
module tb_accumulator_core_param;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       proc_en = 1'b0;
  logic       halt;
  logic       mem_req;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata = 8'h00;
  logic       mem_ack = 1'b0;
  logic [7:0] io_in = 8'h00;
  logic [7:0] io_out;
  logic       scan_enable = 1'b0;
  logic       scan_in = 1'b0;
  logic       scan_out;

  int n_vec = 0;
  int n_fail = 0;

  logic [7:0] mem [256];
  int         waits = 0;
  int         wait_cnt = 0;
  logic [7:0] addr_log [$];
  logic [7:0] io_log [$];
  logic [7:0] last_io = 8'h00;

  accumulator_core_param #(.DATA_W(8), .ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .proc_en(proc_en), .halt(halt),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .io_in(io_in), .io_out(io_out), .scan_enable(scan_enable),
    .scan_in(scan_in), .scan_out(scan_out)
  );

  always #5 clk = ~clk;

  // Memory model: ack after 'waits' idle request cycles, decided mid-cycle.
  always @(negedge clk) begin
    if (mem_req) begin
      if (wait_cnt >= waits) begin
        mem_ack = 1'b1;
        wait_cnt = 0;
        addr_log.push_back(mem_addr);
        if (mem_we) mem[mem_addr] = mem_wdata;
        else        mem_rdata = mem[mem_addr];
      end else begin
        mem_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      mem_ack = 1'b0;
      wait_cnt = 0;
    end
  end

  // Record every change of the output port.
  always @(negedge clk) begin
    if (io_out !== last_io) begin
      io_log.push_back(io_out);
      last_io = io_out;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    wait_cnt = 0;
    addr_log.delete();
    io_log.delete();
    last_io = 8'h00;
  endtask

  task automatic load_basic();
    clear_mem();
    mem[0] = 8'h05;
    mem[1] = 8'h71;
    mem[5] = 8'h7F;
  endtask

  task automatic test_reset();
    load_basic();
    waits = 100;
    proc_en = 1'b1;
    apply_reset();
    tick(2);
    n_vec++;
    if (mem_req !== 1'b1) begin n_fail++; $display("FAIL reset_prefetch_req got %0b want 1", mem_req); end
    rst_n = 1'b0;
    tick(2);
    n_vec++;
    if ({mem_req, mem_we, halt} !== 3'b000) begin
      n_fail++; $display("FAIL reset_ctrl got req/we/halt=%03b want 000", {mem_req, mem_we, halt});
    end
    n_vec++;
    if ({io_out, mem_wdata, mem_addr} !== 24'h000000) begin
      n_fail++; $display("FAIL reset_data got io/acc/addr=%06h want 000000", {io_out, mem_wdata, mem_addr});
    end
    n_vec++;
    if (scan_out !== 1'b0) begin n_fail++; $display("FAIL reset_scan_out got %0b want 0", scan_out); end
    rst_n = 1'b1;
  endtask

  task automatic test_zero_wait();
    load_basic();
    waits = 0;
    proc_en = 1'b1;
    apply_reset();
    tick(3);
    n_vec++;
    if (mem_wdata !== 8'h7F) begin n_fail++; $display("FAIL zw_acc_3 got %02h want 7f", mem_wdata); end
    tick(1);
    n_vec++;
    if (mem_wdata !== 8'h80) begin n_fail++; $display("FAIL zw_acc_4 got %02h want 80", mem_wdata); end
    n_vec++;
    if (addr_log.size() != 3 || addr_log[0] !== 8'h00 || addr_log[1] !== 8'h05 || addr_log[2] !== 8'h01) begin
      n_fail++; $display("FAIL zw_addrs got %p want 0,5,1", addr_log);
    end
  endtask

  task automatic test_wait_states();
    int bad;
    logic [7:0] exp_addr;
    load_basic();
    waits = 3;
    proc_en = 1'b1;
    apply_reset();
    bad = 0;
    for (int c = 1; c <= 16; c++) begin
      tick(1);
      exp_addr = (c < 4) ? 8'h00 : (c < 8) ? 8'h05 : 8'h01;
      if ((c % 4) != 0 && c < 12) begin
        if (mem_req !== 1'b1 || mem_addr !== exp_addr || mem_we !== 1'b0) bad++;
      end
      if (c == 12) begin
        n_vec++;
        if (mem_wdata !== 8'h7F) begin n_fail++; $display("FAIL ws_acc_12 got %02h want 7f", mem_wdata); end
      end
      if (c == 13) begin
        n_vec++;
        if (mem_wdata !== 8'h80) begin n_fail++; $display("FAIL ws_acc_13 got %02h want 80", mem_wdata); end
      end
    end
    n_vec++;
    if (mem_wdata !== 8'h80) begin n_fail++; $display("FAIL ws_acc_16 got %02h want 80", mem_wdata); end
    n_vec++;
    if (bad != 0) begin n_fail++; $display("FAIL ws_bus_stable got %0d unstable cycles want 0", bad); end
  endtask

  task automatic test_wrap();
    clear_mem();
    mem[0] = 8'h9A;
    waits = 0;
    proc_en = 1'b1;
    apply_reset();
    tick(2);
    n_vec++;
    if (mem_req !== 1'b1 || mem_addr !== 8'hFF) begin
      n_fail++; $display("FAIL wrap_pc got req=%0b addr=%02h want 1/ff", mem_req, mem_addr);
    end
    clear_mem();
    mem[0] = 8'h08;
    mem[1] = 8'h29;
    mem[8] = 8'hFF;
    mem[9] = 8'h02;
    apply_reset();
    tick(4);
    n_vec++;
    if (mem_wdata !== 8'h01) begin n_fail++; $display("FAIL wrap_add got %02h want 01", mem_wdata); end
  endtask

  task automatic test_isa();
    logic [7:0] prog [24];
    int cyc;
    prog = '{8'h81, 8'h0E, 8'h6F, 8'hE8, 8'h3D, 8'hD3, 8'hDA, 8'h5C,
             8'h1B, 8'hE0, 8'h92, 8'hE8, 8'hFF, 8'hA1, 8'h77, 8'hE8,
             8'hC0, 8'h4A, 8'hE8, 8'h7A, 8'hB0, 8'hFF, 8'hE8, 8'hFF};
    clear_mem();
    for (int i = 0; i < 24; i++) mem[i] = prog[i];
    mem[8'h1A] = 8'h0F;
    mem[8'h1C] = 8'h01;
    mem[8'h1D] = 8'hC4;
    mem[8'h1E] = 8'h3C;
    mem[8'h1F] = 8'hFF;
    io_in = 8'h00;
    waits = 0;
    proc_en = 1'b1;
    apply_reset();
    cyc = 0;
    while (halt !== 1'b1 && cyc < 300) begin
      tick(1);
      cyc++;
    end
    n_vec++;
    if (halt !== 1'b1) begin n_fail++; $display("FAIL isa_halt_timeout got halt=%0b want 1", halt); end
    n_vec++;
    if (io_out !== 8'h16) begin n_fail++; $display("FAIL isa_io_final got %02h want 16", io_out); end
    n_vec++;
    if (mem[8'h1B] !== 8'h3F) begin n_fail++; $display("FAIL isa_sta got %02h want 3f", mem[8'h1B]); end
    n_vec++;
    if (io_log.size() != 4 || io_log[0] !== 8'hC3 || io_log[1] !== 8'h07 ||
        io_log[2] !== 8'h0C || io_log[3] !== 8'h16) begin
      n_fail++; $display("FAIL isa_io_seq got %p want c3,07,0c,16", io_log);
    end
    tick(5);
    n_vec++;
    if (halt !== 1'b1 || mem_req !== 1'b0) begin
      n_fail++; $display("FAIL isa_halt_idle got halt=%0b req=%0b want 1/0", halt, mem_req);
    end
  endtask

  task automatic test_pause();
    int bad;
    clear_mem();
    mem[0] = 8'h08;
    mem[1] = 8'h19;
    mem[8] = 8'h5A;
    waits = 3;
    proc_en = 1'b1;
    apply_reset();
    tick(14);
    proc_en = 1'b0;
    n_vec++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 8'h09) begin
      n_fail++; $display("FAIL pause_sta_open got req=%0b we=%0b addr=%02h want 1/1/09", mem_req, mem_we, mem_addr);
    end
    tick(2);
    n_vec++;
    if (mem[9] !== 8'h5A) begin n_fail++; $display("FAIL pause_sta_done got %02h want 5a", mem[9]); end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (mem_req !== 1'b0) bad++;
      tick(1);
    end
    n_vec++;
    if (bad != 0) begin n_fail++; $display("FAIL pause_no_req got %0d req cycles want 0", bad); end
    proc_en = 1'b1;
    @(negedge clk);
    n_vec++;
    if (mem_req !== 1'b1 || mem_addr !== 8'h02) begin
      n_fail++; $display("FAIL pause_resume got req=%0b addr=%02h want 1/02", mem_req, mem_addr);
    end
    tick(1);
  endtask

  task automatic test_scan();
`ifdef SCAN_CHAIN_EN
    logic [37:0] pat;
    int bad;
    pat = 38'h25_A3C6_9E14;
    proc_en = 1'b1;
    waits = 0;
    apply_reset();
    scan_enable = 1'b1;
    bad = 0;
    for (int i = 37; i >= 0; i--) begin
      scan_in = pat[i];
      tick(1);
      if (mem_req !== 1'b0) bad++;
    end
    n_vec++;
    if (bad != 0) begin n_fail++; $display("FAIL scan_req got %0d req cycles want 0", bad); end
    n_vec++;
    if (io_out !== pat[37:30] || mem_wdata !== pat[29:22] || halt !== 1'b0) begin
      n_fail++; $display("FAIL scan_load got io=%02h acc=%02h halt=%0b want %02h/%02h/0",
                         io_out, mem_wdata, halt, pat[37:30], pat[29:22]);
    end
    bad = 0;
    scan_in = 1'b0;
    for (int i = 37; i >= 0; i--) begin
      if (scan_out !== pat[i]) bad++;
      tick(1);
    end
    n_vec++;
    if (bad != 0) begin n_fail++; $display("FAIL scan_unload got %0d bad bits want 0", bad); end
    scan_enable = 1'b0;
`else
    load_basic();
    waits = 0;
    proc_en = 1'b1;
    apply_reset();
    scan_enable = 1'b1;
    scan_in = 1'b1;
    tick(4);
    n_vec++;
    if (mem_wdata !== 8'h80 || scan_out !== 1'b0) begin
      n_fail++; $display("FAIL scan_ignored got acc=%02h so=%0b want 80/0", mem_wdata, scan_out);
    end
    scan_enable = 1'b0;
    scan_in = 1'b0;
`endif
  endtask

  initial begin
    clear_mem();
    #1;
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_wrap();
    test_isa();
    test_pause();
    test_scan();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
